riscv_ex_muldiv_ctrl: RTL and testbench

Multi-cycle sequencer for RV32M instructions in the EX stage. It detects MUL/DIV-class ops in EX, captures the forwarded operands, and runs a shared radix-2 iterative multiply/divide engine. While the engine runs it stalls the pipeline, then presents the result for one cycle so the existing EX/MEM path can capture it. It sits beside the EX ALU; the EX output mux selects o_EX_md_out when o_EX_md_valid=1.

---
 rtl/riscv_ex_muldiv_ctrl.sv | 138 +++++++++++++
 tb/tb_riscv_ex_muldiv_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ex_muldiv_ctrl.sv
// RV32M sequencer for the EX stage: detects M-ops, stalls the pipe while a shared
// radix-2 shift-add / restoring-divide engine iterates, then presents the result for one cycle.
module riscv_ex_muldiv_ctrl #(
  parameter int XLEN   = 32,
  parameter int N_ITER = XLEN,
  parameter int CNT_W  = $clog2(N_ITER)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_EX_valid,
  input  logic [6:0]      i_EX_opcode,
  input  logic [2:0]      i_EX_funct3,
  input  logic [6:0]      i_EX_funct7,
  input  logic [XLEN-1:0] i_EX_rs1_data,
  input  logic [XLEN-1:0] i_EX_rs2_data,
  input  logic            i_flush,
  output logic            o_EX_stall,
  output logic            o_EX_md_valid,
  output logic [XLEN-1:0] o_EX_md_out,
  output logic            o_EX_md_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(N_ITER - 1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opa, r_opb;
  logic [2:0]        r_f3;
  logic              r_neg_a, r_neg_b, r_divz, r_ovf;

  logic            w_is_m, w_start, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b, w_divz, w_ovf;
  logic [XLEN-1:0] w_abs_a, w_abs_b;

  assign w_is_m  = i_EX_valid && (i_EX_opcode == 7'b0110011) && (i_EX_funct7 == 7'b0000001);
  assign w_start = (r_state == S_IDLE) && w_is_m && !i_flush;

  // A is signed for MUL/MULH/MULHSU/DIV/REM; B only for MUL/MULH/DIV/REM.
  assign w_sgn_a = i_EX_funct3[2] ? !i_EX_funct3[0] : (i_EX_funct3 != 3'b011);
  assign w_sgn_b = i_EX_funct3[2] ? !i_EX_funct3[0] : !i_EX_funct3[1];
  assign w_neg_a = w_sgn_a && i_EX_rs1_data[XLEN-1];
  assign w_neg_b = w_sgn_b && i_EX_rs2_data[XLEN-1];
  assign w_abs_a = w_neg_a ? -i_EX_rs1_data : i_EX_rs1_data;
  assign w_abs_b = w_neg_b ? -i_EX_rs2_data : i_EX_rs2_data;
  assign w_divz  = i_EX_funct3[2] && (i_EX_rs2_data == '0);
  assign w_ovf   = i_EX_funct3[2] && !i_EX_funct3[0] &&
                   (i_EX_rs1_data == MIN_NEG) && (i_EX_rs2_data == '1);

  // Multiply step: add multiplicand into the high half, then shift the whole product right.
  logic [XLEN:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_opb[0] ? {1'b0, r_opa} : '0);

  // Divide step: high half is the partial remainder, low half collects quotient bits.
  logic [XLEN:0]   w_div_trial;
  logic [XLEN-1:0] w_div_diff, w_rem_nxt;
  logic            w_div_ge;
  assign w_div_trial = {r_acc[2*XLEN-1:XLEN], r_opa[XLEN-1]};
  assign w_div_ge    = (w_div_trial >= {1'b0, r_opb});
  assign w_div_diff  = w_div_trial[XLEN-1:0] - r_opb;
  assign w_rem_nxt   = w_div_ge ? w_div_diff : w_div_trial[XLEN-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = (w_divz || w_ovf) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == LAST) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_f3    <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_divz  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opa   <= w_abs_a;
      r_opb   <= w_abs_b;
      r_f3    <= i_EX_funct3;
      r_neg_a <= w_neg_a;
      r_neg_b <= w_neg_b;
      r_divz  <= w_divz;
      r_ovf   <= w_ovf;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_f3[2]) begin
        r_acc <= {w_rem_nxt, r_acc[XLEN-2:0], w_div_ge};
        r_opa <= r_opa << 1;
      end else begin
        r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
        r_opb <= r_opb >> 1;
      end
    end
  end

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_a_orig, w_res;
  assign w_prod   = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
  assign w_quo    = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem    = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_a_orig = r_neg_a ? -r_opa : r_opa;

  always_comb begin
    w_res = '0;
    case (r_f3)
      3'b000:                 w_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_res = r_divz ? '1 : (r_ovf ? MIN_NEG : w_quo);
      default:                w_res = r_divz ? w_a_orig : (r_ovf ? '0 : w_rem);
    endcase
  end

  // Stall is gated by reset so every output reads 0 while reset is held.
  assign o_EX_stall    = i_rstn && (((r_state == S_IDLE) && w_is_m && !i_flush) ||
                                    (r_state == S_CALC));
  assign o_EX_md_busy  = (r_state == S_CALC);
  assign o_EX_md_valid = (r_state == S_DONE) && !i_flush;
  assign o_EX_md_out   = o_EX_md_valid ? w_res : '0;

endmodule

// File: tb/tb_riscv_ex_muldiv_ctrl.sv
// Randomized bench for riscv_ex_muldiv_ctrl: a cycle-timeline reference model computes
// results with plain 64-bit arithmetic and is compared against the DUT every cycle.
module tb_riscv_ex_muldiv_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_EX_valid;
  logic [6:0]  i_EX_opcode;
  logic [2:0]  i_EX_funct3;
  logic [6:0]  i_EX_funct7;
  logic [31:0] i_EX_rs1_data, i_EX_rs2_data;
  logic        i_flush;
  logic        o_EX_stall, o_EX_md_valid, o_EX_md_busy;
  logic [31:0] o_EX_md_out;

  riscv_ex_muldiv_ctrl dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_EX_valid(i_EX_valid),
    .i_EX_opcode(i_EX_opcode), .i_EX_funct3(i_EX_funct3), .i_EX_funct7(i_EX_funct7),
    .i_EX_rs1_data(i_EX_rs1_data), .i_EX_rs2_data(i_EX_rs2_data), .i_flush(i_flush),
    .o_EX_stall(o_EX_stall), .o_EX_md_valid(o_EX_md_valid),
    .o_EX_md_out(o_EX_md_out), .o_EX_md_busy(o_EX_md_busy)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // reference arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        q = sa / sb; return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // model state: one op in flight, age counted in cycles since its detect cycle
  bit          m_active = 0;
  int          m_age = 0, m_len = 0;
  logic [31:0] m_res = '0;
  logic [31:0] last_out = '0;
  int          last_valid_cyc = -1;
  int          n_valid = 0;

  // scoreboard: compare every cycle away from the active edge, then advance the model
  always @(negedge i_clk) begin
    bit          is_m;
    logic        e_stall, e_valid, e_busy;
    logic [31:0] e_out;
    is_m = i_EX_valid && i_EX_opcode == 7'b0110011 && i_EX_funct7 == 7'b0000001;
    e_stall = 0; e_valid = 0; e_busy = 0; e_out = '0;
    if (!i_rstn) begin
      e_stall = 0;
    end else if (m_active && m_age < m_len) begin
      e_stall = 1; e_busy = 1;
    end else if (m_active) begin
      e_valid = 1; e_out = m_res;
    end else begin
      e_stall = is_m && !i_flush;
    end
    check("stall", 32'(o_EX_stall), 32'(e_stall));
    check("valid", 32'(o_EX_md_valid), 32'(e_valid));
    check("busy", 32'(o_EX_md_busy), 32'(e_busy));
    if (e_valid || !i_rstn) check("md_out", o_EX_md_out, e_out);
    if (o_EX_md_valid) begin
      last_out = o_EX_md_out;
      last_valid_cyc = cyc;
      n_valid++;
    end
    if (!i_rstn || i_flush) m_active = 0;
    else if (m_active) begin
      if (m_age == m_len) m_active = 0;
      else m_age++;
    end else if (is_m) begin
      m_active = 1;
      m_age = 1;
      m_len = is_fast(i_EX_funct3, i_EX_rs1_data, i_EX_rs2_data) ? 1 : 33;
      m_res = ref_res(i_EX_funct3, i_EX_rs1_data, i_EX_rs2_data);
    end
  end

  // driver tasks
  task automatic set_bubble();
    i_EX_valid = 0; i_EX_opcode = 7'b0010011; i_EX_funct3 = 3'd0; i_EX_funct7 = 7'd0;
    i_flush = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0: begin i_EX_valid = 1; i_EX_opcode = 7'b0110011; i_EX_funct7 = 7'd0; end
        1: begin i_EX_valid = 0; i_EX_opcode = 7'b0110011; i_EX_funct7 = 7'd1; end
        2: begin i_EX_valid = 1; i_EX_opcode = 7'b0110011; i_EX_funct7 = 7'h20; end
        default: begin i_EX_valid = 0; i_EX_opcode = 7'b0010011; i_EX_funct7 = 7'd0; end
      endcase
      i_EX_funct3 = 3'($urandom_range(0, 7));
      i_EX_rs1_data = $urandom; i_EX_rs2_data = $urandom;
      @(posedge i_clk); #1;
    end
    set_bubble();
  endtask

  // Holds the M-op in EX until the pipeline would advance; flush_at<0 means no kill.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at);
    int  len, c0;
    bit  killed;
    len = is_fast(f3, a, b) ? 1 : 33;
    c0 = cyc;
    killed = 0;
    i_EX_valid = 1; i_EX_opcode = 7'b0110011; i_EX_funct7 = 7'b0000001;
    i_EX_funct3 = f3; i_EX_rs1_data = a; i_EX_rs2_data = b; i_flush = 0;
    for (int c = 0; c <= len && !killed; c++) begin
      if (c == flush_at) i_flush = 1;
      @(posedge i_clk); #1;
      i_flush = 0;
      if (c == flush_at) killed = 1;
      else begin
        i_EX_rs1_data = $urandom; i_EX_rs2_data = $urandom;
      end
    end
    set_bubble();
    if (flush_at < 0) check("latency", 32'(last_valid_cyc - c0), 32'(len));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int v1, nv;
    i_rstn = 0;
    i_EX_rs1_data = '0; i_EX_rs2_data = '0;
    set_bubble();
    repeat (3) @(posedge i_clk);
    // M-op sitting in EX while reset is held must not raise any output
    i_EX_valid = 1; i_EX_opcode = 7'b0110011; i_EX_funct7 = 7'd1;
    @(posedge i_clk); #1;
    set_bubble();
    i_rstn = 1;
    @(posedge i_clk); #1;

    // hand-computed pins of the reference model
    check("pin_mul", ref_res(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    check("pin_mulhu", ref_res(3'd3, 32'd7, 32'hFFFFFFFD), 32'h00000006);
    check("pin_mulh", ref_res(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
    check("pin_mulhsu", ref_res(3'd2, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
    check("pin_div", ref_res(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    check("pin_rem", ref_res(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

    // directed ops against literal results
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, -1);          check("mul", last_out, 32'hFFFFFFEB);
    do_op(3'd3, 32'd7, 32'hFFFFFFFD, -1);          check("mulhu", last_out, 32'h00000006);
    do_op(3'd1, 32'h80000000, 32'h80000000, -1);   check("mulh", last_out, 32'h40000000);
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, -1);          check("mulhsu", last_out, 32'hFFFFFFFF);
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, -1);          check("div", last_out, 32'hFFFFFFFD);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, -1);          check("rem", last_out, 32'hFFFFFFFF);
    do_op(3'd5, 32'd100, 32'd7, -1);               check("divu", last_out, 32'd14);
    do_op(3'd7, 32'd100, 32'd7, -1);               check("remu", last_out, 32'd2);
    do_op(3'd5, 32'd5, 32'd0, -1);                 check("divu_by0", last_out, 32'hFFFFFFFF);
    do_op(3'd6, 32'd5, 32'd0, -1);                 check("rem_by0", last_out, 32'd5);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, -1);   check("div_ovf", last_out, 32'h80000000);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, -1);   check("rem_ovf", last_out, 32'h0);
    idle(4);

    // back-to-back MULs
    do_op(3'd0, 32'd3, 32'd5, -1);
    check("b2b_first", last_out, 32'd15);
    v1 = last_valid_cyc;
    do_op(3'd0, 32'hFFFFFFFF, 32'd9, -1);
    check("b2b_second", last_out, 32'hFFFFFFF7);
    check("b2b_spacing", 32'(last_valid_cyc - v1), 32'd34);

    // flush during CALC kills the op
    nv = n_valid;
    do_op(3'd4, 32'd100, 32'd7, 10);
    idle(40);
    check("flush_no_valid", 32'(n_valid), 32'(nv));

    // reset mid-CALC aborts without a result
    nv = n_valid;
    i_EX_valid = 1; i_EX_opcode = 7'b0110011; i_EX_funct7 = 7'd1;
    i_EX_funct3 = 3'd0; i_EX_rs1_data = 32'd11; i_EX_rs2_data = 32'd13;
    repeat (15) begin @(posedge i_clk); #1; end
    i_rstn = 0;
    repeat (2) begin @(posedge i_clk); #1; end
    set_bubble();
    i_rstn = 1;
    idle(40);
    check("reset_no_valid", 32'(n_valid), 32'(nv));

    // randomized ops with random gaps and occasional kills
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          fa;
      f3 = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      fa = -1;
      if ($urandom_range(0, 7) == 0) fa = $urandom_range(0, is_fast(f3, a, b) ? 0 : 32);
      do_op(f3, a, b, fa);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
